// File: rtl/param_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with enable prescaler, clear/load, wrap or one-shot mode.
// Latency: counter, tc, done and wrapped are registered and update on the step edge itself.
// Backpressure: none; en freezes prescaler and counter in place, preserving the prescale phase.
module param_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 15,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             done,
  output logic             wrapped
);

  // Parameter sanity: a bad configuration must stop elaboration, not silently misbehave.
  if (WIDTH < 1) begin : g_bad_width
    $error("param_counter: WIDTH must be at least 1");
  end
  if (MAX_VAL < 1 || longint'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("param_counter: MAX_VAL must be in 1 .. 2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_counter: PRESCALE must be at least 1");
  end
  if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
    $error("param_counter: RESET_VAL must be in 0 .. MAX_VAL");
  end

  localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    psc_q, psc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             step;

  // A count step happens on the last enabled cycle of each prescale period.
  assign step = en && (psc_q == PS_LAST);

  // Next-state: clr beats load beats step; tc is a single-edge pulse by default.
  always_comb begin
    psc_d  = psc_q;
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    done_d = done_q;
    wrap_d = wrap_q;
    if (clr) begin
      psc_d  = '0;
      cnt_d  = RST_C;
      done_d = 1'b0;
      wrap_d = 1'b0;
    end else if (load) begin
      psc_d  = '0;
      cnt_d  = (load_val > MAX_C) ? MAX_C : load_val;
      done_d = 1'b0;
    end else begin
      if (en) begin
        psc_d = step ? '0 : psc_q + PW'(1);
      end
      if (step) begin
        if (oneshot) begin
          // One-shot: stop at the end value; a step from the end value just latches done.
          if (!done_q) begin
            if (up) begin
              if (cnt_q == MAX_C) begin
                done_d = 1'b1;
                tc_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + ONE_C;
                if (cnt_q == MAX_C - ONE_C) begin
                  done_d = 1'b1;
                  tc_d   = 1'b1;
                end
              end
            end else begin
              if (cnt_q == '0) begin
                done_d = 1'b1;
                tc_d   = 1'b1;
              end else begin
                cnt_d = cnt_q - ONE_C;
                if (cnt_q == ONE_C) begin
                  done_d = 1'b1;
                  tc_d   = 1'b1;
                end
              end
            end
          end
        end else begin
          // Wrap mode: modulo MAX_VAL+1, terminal event on the wrap edge.
          if (up) begin
            if (cnt_q == MAX_C) begin
              cnt_d  = '0;
              tc_d   = 1'b1;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE_C;
            end
          end else begin
            if (cnt_q == '0) begin
              cnt_d  = MAX_C;
              tc_d   = 1'b1;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE_C;
            end
          end
        end
      end
    end
  end

  // State registers with asynchronous reset to the idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_q  <= '0;
      cnt_q  <= RST_C;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end

  assign counter = cnt_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign wrapped = wrap_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: vector table on a MAX_VAL=9 instance plus
// hand-written sequences for reset, prescaling, back-to-back tc and async reset.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, oneshot = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] c0, c9, cp, c1;
  logic       tc0, tc9, tcp, tc1;
  logic       dn0, dn9, dnp, dn1;
  logic       wr0, wr9, wrp, wr1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_counter u_d0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .oneshot(oneshot), .clr(clr), .load(load),
    .load_val(load_val), .counter(c0), .tc(tc0), .done(dn0), .wrapped(wr0));

  param_counter #(.MAX_VAL(9)) u_d9 (
    .clk(clk), .rst(rst), .en(en), .up(up), .oneshot(oneshot), .clr(clr), .load(load),
    .load_val(load_val), .counter(c9), .tc(tc9), .done(dn9), .wrapped(wr9));

  param_counter #(.PRESCALE(3)) u_dp (
    .clk(clk), .rst(rst), .en(en), .up(up), .oneshot(oneshot), .clr(clr), .load(load),
    .load_val(load_val), .counter(cp), .tc(tcp), .done(dnp), .wrapped(wrp));

  param_counter #(.MAX_VAL(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .oneshot(oneshot), .clr(clr), .load(load),
    .load_val(load_val), .counter(c1), .tc(tc1), .done(dn1), .wrapped(wr1));

  typedef struct {
    logic       clr, load, en, up, os;
    logic [3:0] lv;
    logic [3:0] c;
    logic       tc, dn, wr;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic a_clr, input logic a_load, input logic [3:0] a_lv,
                     input logic a_en, input logic a_up, input logic a_os,
                     input logic [3:0] e_c, input logic e_tc, input logic e_dn, input logic e_wr);
    vec_t v;
    v.clr = a_clr; v.load = a_load; v.lv = a_lv; v.en = a_en; v.up = a_up; v.os = a_os;
    v.c = e_c; v.tc = e_tc; v.dn = e_dn; v.wr = e_wr;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic a_clr, input logic a_load, input logic [3:0] a_lv,
                       input logic a_en, input logic a_up, input logic a_os);
    clr = a_clr; load = a_load; load_val = a_lv; en = a_en; up = a_up; oneshot = a_os;
  endtask

  initial begin
    // ---------------- reset / basic counting on defaults ----------------
    en = 1'b1; up = 1'b1;
    #8;
    chk("rst cnt", c0, 0);
    chk("rst tc", tc0, 0);
    chk("rst done", dn0, 0);
    chk("rst wrapped", wr0, 0);
    #4 rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("basic cnt e%0d", k), c0, k);
      chk($sformatf("basic tc e%0d", k), tc0, 0);
    end

    // ---------------- vector table on the MAX_VAL=9 instance ----------------
    add(1,0,4'd0, 0,1,0,  4'd0,0,0,0);
    for (int k = 1; k <= 9; k++) add(0,0,4'd0, 1,1,0, 4'(k),0,0,0);
    add(0,0,4'd0, 1,1,0,  4'd0,1,0,1);   // 9 -> 0 wraps
    add(0,0,4'd0, 0,1,0,  4'd0,0,0,1);   // tc is one cycle, wrapped sticky
    add(1,0,4'd0, 0,1,0,  4'd0,0,0,0);   // clr drops wrapped
    add(0,1,4'd0, 0,0,0,  4'd0,0,0,0);   // load 0
    add(0,0,4'd0, 1,0,0,  4'd9,1,0,1);   // down wrap 0 -> 9
    add(0,0,4'd0, 1,0,0,  4'd8,0,0,1);
    add(0,1,4'd7, 0,1,1,  4'd7,0,0,1);   // load keeps wrapped
    add(0,0,4'd0, 1,1,1,  4'd8,0,0,1);
    add(0,0,4'd0, 1,1,1,  4'd9,1,1,1);   // reaches end
    for (int k = 0; k < 5; k++) add(0,0,4'd0, 1,1,1, 4'd9,0,1,1);
    add(0,0,4'd0, 1,0,0,  4'd8,0,1,1);   // wrap mode steps, done stays
    add(0,0,4'd0, 1,0,1,  4'd8,0,1,1);   // one-shot with done holds
    add(0,1,4'd3, 0,1,1,  4'd3,0,0,1);   // load clears done
    add(0,0,4'd0, 1,0,1,  4'd2,0,0,1);
    add(0,0,4'd0, 1,0,1,  4'd1,0,0,1);
    add(0,0,4'd0, 1,0,1,  4'd0,1,1,1);
    add(0,0,4'd0, 1,0,1,  4'd0,0,1,1);
    add(0,1,4'd0, 0,0,1,  4'd0,0,0,1);
    add(0,0,4'd0, 1,0,1,  4'd0,1,1,1);   // step from end value: hold, done
    add(1,1,4'd5, 1,1,0,  4'd0,0,0,0);   // clr beats load
    add(0,1,4'd12,0,1,0,  4'd9,0,0,0);   // clamp
    add(0,1,4'd15,0,1,0,  4'd9,0,0,0);
    add(0,1,4'd4, 1,1,0,  4'd4,0,0,0);   // load beats step
    add(0,0,4'd0, 1,1,0,  4'd5,0,0,0);

    foreach (vt[i]) begin
      drive(vt[i].clr, vt[i].load, vt[i].lv, vt[i].en, vt[i].up, vt[i].os);
      tick();
      chk($sformatf("v%0d cnt", i), c9, vt[i].c);
      chk($sformatf("v%0d tc", i), tc9, vt[i].tc);
      chk($sformatf("v%0d done", i), dn9, vt[i].dn);
      chk($sformatf("v%0d wrapped", i), wr9, vt[i].wr);
    end

    // ---------------- prescaler (PRESCALE=3) ----------------
    drive(1,0,4'd0, 0,1,0);
    tick();
    chk("psc clr", cp, 0);
    drive(0,0,4'd0, 1,1,0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("psc e%0d", k), cp, k / 3);
    end
    tick();
    chk("psc phase1", cp, 3);
    en = 1'b0;
    tick();
    chk("psc frz1", cp, 3);
    tick();
    chk("psc frz2", cp, 3);
    en = 1'b1;
    tick();
    chk("psc phase2", cp, 3);
    tick();
    chk("psc step", cp, 4);
    chk("psc tc", tcp, 0);

    // ---------------- back-to-back tc (MAX_VAL=1) ----------------
    drive(1,0,4'd0, 0,1,0);
    tick();
    drive(0,0,4'd0, 1,1,0);
    tick();
    chk("b2b cnt0", c1, 1);
    chk("b2b tc0", tc1, 0);
    tick();
    chk("b2b cnt1", c1, 0);
    chk("b2b tc1", tc1, 1);
    up = 1'b0;
    tick();
    chk("b2b cnt2", c1, 1);
    chk("b2b tc2", tc1, 1);
    up = 1'b1;
    tick();
    chk("b2b cnt3", c1, 0);
    chk("b2b tc3", tc1, 1);
    en = 1'b0;
    tick();
    chk("b2b tc4", tc1, 0);

    // ---------------- async reset mid-count ----------------
    drive(1,0,4'd0, 0,1,0);
    tick();
    drive(0,0,4'd0, 1,1,0);
    tick(); tick(); tick();
    chk("arst pre", c9, 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst cnt", c9, 0);
    chk("arst tc", tc9, 0);
    tick();
    chk("arst hold", c9, 0);
    rst = 1'b0;
    tick();
    chk("arst resume", c9, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
